// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// ExcCode values, PRId and the exception handler vector.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] PRID_VALUE   = 32'h0000_4CE0;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // A delay-slot victim restarts at its branch; the low two bits are always dropped.
  function automatic logic [31:0] epc_align(input logic [31:0] pc, input logic in_bd);
    logic [31:0] target;
    target = in_bd ? (pc - 32'd4) : pc;
    return target & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Interrupt/exception request and priority: decides whether the handler is
// entered this cycle and which ExcCode gets recorded.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code,
  output logic       int_req,
  output logic [4:0] code_sel
);

  logic int_pend_s;
  logic exc_pend_s;

  // Interrupts outrank a synchronous exception and record code 0.
  always_comb begin
    int_pend_s = ie & ~exl & (|(hw_int & im));
    exc_pend_s = ~exl & (exc_code != 5'd0);
    int_req    = int_pend_s | exc_pend_s;
    if (int_pend_s) begin
      code_sel = EXC_INT;
    end else begin
      code_sel = exc_code;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: SR, Cause, EPC, PRId and mtc0/mfc0 access.
// Optional BadVAddr (reg 8) and badvaddr_in port under CP0_BADVADDR_EN.
module cp0_exc_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        eret,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] badvaddr_in,
`endif
  output logic        int_req,
  output logic [31:0] epc_out
);

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [5:0]  im_q, im_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0] bva_q, bva_d;
`endif

  logic [4:0]  code_sel_s;
  logic        wr_sr_s;
  logic        wr_epc_s;

  cp0_int_arb u_arb (
    .ie       (ie_q),
    .exl      (exl_q),
    .im       (im_q),
    .hw_int   (hw_int),
    .exc_code (exc_code),
    .int_req  (int_req),
    .code_sel (code_sel_s)
  );

  // Next state: exception entry overrides mtc0; eret clears EXL after any SR write.
  always_comb begin
    ie_d     = ie_q;
    exl_d    = exl_q;
    im_d     = im_q;
    bd_d     = bd_q;
    ip_d     = hw_int;
    exc_d    = exc_q;
    epc_d    = epc_q;
    wr_sr_s  = we & (addr == REG_SR);
    wr_epc_s = we & (addr == REG_EPC);
`ifdef CP0_BADVADDR_EN
    bva_d    = bva_q;
`endif
    if (int_req) begin
      exl_d = 1'b1;
      exc_d = code_sel_s;
      bd_d  = bd;
      epc_d = epc_align(vpc, bd);
`ifdef CP0_BADVADDR_EN
      if ((code_sel_s == EXC_ADEL) || (code_sel_s == EXC_ADES)) begin
        bva_d = badvaddr_in;
      end else begin
        bva_d = bva_q;
      end
`endif
    end else begin
      ie_d  = wr_sr_s  ? wdata[SR_IE]             : ie_q;
      im_d  = wr_sr_s  ? wdata[SR_IM_HI:SR_IM_LO] : im_q;
      exl_d = (wr_sr_s ? wdata[SR_EXL] : exl_q) & ~eret;
      epc_d = wr_epc_s ? wdata                    : epc_q;
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im_q  <= 6'd0;
      bd_q  <= 1'b0;
      ip_q  <= 6'd0;
      exc_q <= 5'd0;
      epc_q <= 32'd0;
`ifdef CP0_BADVADDR_EN
      bva_q <= 32'd0;
`endif
    end else begin
      ie_q  <= ie_d;
      exl_q <= exl_d;
      im_q  <= im_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
`ifdef CP0_BADVADDR_EN
      bva_q <= bva_d;
`endif
    end
  end

  // mfc0 read mux; unimplemented numbers read zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_SR: begin
        rdata[SR_IE]                    = ie_q;
        rdata[SR_EXL]                   = exl_q;
        rdata[SR_IM_HI:SR_IM_LO]        = im_q;
      end
      REG_CAUSE: begin
        rdata[CAUSE_BD]                 = bd_q;
        rdata[CAUSE_IP_HI:CAUSE_IP_LO]  = ip_q;
        rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
      end
      REG_EPC:  rdata = epc_q;
      REG_PRID: rdata = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: rdata = bva_q;
`endif
      default:  rdata = 32'd0;
    endcase
  end

  assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: word-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_cp0_exc_unit;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] badvaddr_in;

  int checks = 0;
  int errors = 0;

  cp0_exc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .vpc         (vpc),
    .bd          (bd),
    .exc_code    (exc_code),
    .hw_int      (hw_int),
    .eret        (eret),
`ifdef CP0_BADVADDR_EN
    .badvaddr_in (badvaddr_in),
`endif
    .int_req     (int_req),
    .epc_out     (epc_out)
  );

  always #10 clk = ~clk;

  // Reference model: whole-register words updated by the architectural rules.
  logic [31:0] m_sr, m_cause, m_epc, m_bva;
  bit          m_valid = 1'b0;

  function automatic logic m_int_pending(input logic [31:0] sr, input logic [5:0] hw);
    return sr[0] && !sr[1] && ((hw & sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req(input logic [31:0] sr, input logic [5:0] hw, input logic [4:0] ec);
    return m_int_pending(sr, hw) || (!sr[1] && ec != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4CE0;
`ifdef CP0_BADVADDR_EN
      5'd8:    return m_bva;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [4:0] code;
    if (reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0; m_bva = 32'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_req(m_sr, hw_int, exc_code)) begin
        code    = m_int_pending(m_sr, hw_int) ? 5'd0 : exc_code;
        m_cause = {bd, 15'd0, hw_int, 3'd0, code, 2'd0};
        m_epc   = bd ? vpc - 32'd4 : vpc;
        m_epc[1:0] = 2'b00;
        m_sr[1] = 1'b1;
        if (code == 5'd4 || code == 5'd5) m_bva = badvaddr_in;
      end else begin
        if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
        if (we && addr == 5'd14) m_epc = wdata;
        if (eret) m_sr[1] = 1'b0;
        m_cause[15:10] = hw_int;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (int_req !== m_req(m_sr, hw_int, exc_code)) begin
        errors++;
        $display("FAIL model_int_req t=%0t got %b want %b", $time, int_req, m_req(m_sr, hw_int, exc_code));
      end
      checks++;
      if (epc_out !== m_epc) begin
        errors++;
        $display("FAIL model_epc_out t=%0t got %h want %h", $time, epc_out, m_epc);
      end
      checks++;
      if (rdata !== m_read(addr)) begin
        errors++;
        $display("FAIL model_rdata addr=%0d t=%0t got %h want %h", addr, $time, rdata, m_read(addr));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    lit(name, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0; vpc = 32'h0000_1000;
    bd = 1'b0; exc_code = 5'd0; hw_int = 6'd0; eret = 1'b0; badvaddr_in = 32'd0;
    $display("handler vector %h", HANDLER_ADDR);
    cyc(); cyc();
    reset = 1'b0;
    rd(5'd15, 32'h0000_4CE0, "prid");
    rd(5'd12, 32'd0, "sr_reset");
    rd(5'd13, 32'd0, "cause_reset");
    lit("int_reset", {31'd0, int_req}, 32'd0);

    // Enable IE and IM[0], then raise hw_int[0].
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; cyc(); we = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_write");
    hw_int = 6'b000001; #1;
    lit("int_same_cycle", {31'd0, int_req}, 32'd1);
    cyc();
    rd(5'd12, 32'h0000_0403, "sr_exl_int");
    rd(5'd13, 32'h0000_0400, "cause_int");
    lit("epc_int", epc_out, 32'h0000_1000);
    hw_int = 6'd0; eret = 1'b1; cyc(); eret = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_after_eret");

    // Overflow in a delay slot.
    exc_code = EXC_OV; vpc = 32'h0000_3010; bd = 1'b1; cyc(); exc_code = 5'd0; bd = 1'b0;
    lit("epc_bd", epc_out, 32'h0000_300C);
    rd(5'd13, 32'h8000_0030, "cause_ov_bd");
    rd(5'd12, 32'h0000_0403, "sr_exl_ov");

    // Exception masked by EXL, taken after eret.
    exc_code = EXC_RI; #1;
    lit("int_masked_exl", {31'd0, int_req}, 32'd0);
    eret = 1'b1; cyc(); eret = 1'b0;
    lit("int_after_eret", {31'd0, int_req}, 32'd1);
    rd(5'd12, 32'h0000_0401, "sr_eret_clr");
    cyc(); exc_code = 5'd0;
    rd(5'd13, 32'h0000_0028, "cause_ri");
    eret = 1'b1; cyc(); eret = 1'b0;

    // mtc0 EPC colliding with exception entry is dropped.
    exc_code = EXC_OV; vpc = 32'h2222_2226; we = 1'b1; addr = 5'd14; wdata = 32'h0000_3040;
    cyc(); we = 1'b0; exc_code = 5'd0;
    lit("epc_entry_wins", epc_out, 32'h2222_2224);

    // SR write together with eret: EXL comes from eret.
    we = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF; eret = 1'b1; cyc(); eret = 1'b0;
    addr = 5'd13; cyc(); we = 1'b0;
    rd(5'd12, 32'h0000_FC01, "sr_write_eret");
    rd(5'd13, 32'h0000_0030, "cause_not_writable");
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_3040; cyc(); we = 1'b0;
    lit("epc_write", epc_out, 32'h0000_3040);
    rd(5'd9, 32'd0, "unimplemented");

    // Reset in the middle of a handler with an interrupt still asserted.
    hw_int = 6'b100000; #1;
    lit("int_hw5", {31'd0, int_req}, 32'd1);
    cyc();
    rd(5'd12, 32'h0000_FC03, "sr_in_handler");
    reset = 1'b1; cyc(); reset = 1'b0;
    rd(5'd12, 32'd0, "sr_mid_reset");
    rd(5'd13, 32'd0, "cause_mid_reset");
    rd(5'd14, 32'd0, "epc_mid_reset");
    lit("int_mid_reset", {31'd0, int_req}, 32'd0);
    rd(5'd15, 32'h0000_4CE0, "prid_after_reset");

    // Address error: BadVAddr capture when compiled in, zero otherwise.
    hw_int = 6'd0; badvaddr_in = 32'h0000_0003; exc_code = EXC_ADEL; vpc = 32'h0000_2000;
    cyc(); exc_code = 5'd0;
    rd(5'd13, 32'h0000_0010, "cause_adel");
`ifdef CP0_BADVADDR_EN
    rd(5'd8, 32'h0000_0003, "badvaddr_load");
`else
    rd(5'd8, 32'd0, "badvaddr_absent");
`endif
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port we  input  1  mtc0 write enable.
REQ-004 SHALL have port addr  input  5  CP0 register number for read and write.
REQ-005 SHALL have port wdata  input  32  mtc0 write data.
REQ-006 SHALL have port rdata  output  32  mfc0 read data; combinational from addr.
REQ-007 SHALL have port vpc  input  32  PC of the victim instruction at the commit stage.
REQ-008 SHALL have port bd  input  1  victim instruction is in a branch delay slot.
REQ-009 SHALL have port exc_code  input  5  pending synchronous exception code; 0 = none.
REQ-010 SHALL have port hw_int  input  6  hardware interrupt lines, level-sensitive.
REQ-011 SHALL have port eret  input  1  eret is committing this cycle.
REQ-012 SHALL have port int_req  output  1  redirect fetch to handler 0x0000_4180 this cycle.
REQ-013 SHALL have port epc_out  output  32  current EPC, used as the eret target.

Function
REQ-014 SHALL implement SR (reg 12) with fields IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-015 SHALL implement Cause (reg 13) with fields BD[31], IP[15:10] and ExcCode[6:2]; other bits SHALL read 0; Cause SHALL NOT be writable by mtc0.
REQ-016 SHALL implement EPC (reg 14) as 32 bits, writable; PRId (reg 15) SHALL read the constant 0x0000_4CE0.
REQ-017 SHALL return 0 on rdata for any unimplemented address.
REQ-018 SHALL compute int_req combinationally as (IE & !EXL & |(hw_int & IM)) | (!EXL & exc_code != 0).
REQ-019 SHALL give interrupts priority over exceptions when both are pending; the recorded ExcCode SHALL be 0 for an interrupt.
REQ-020 SHALL, on a clock edge with int_req=1, set EXL=1, load ExcCode, set BD=bd, and load EPC with vpc-4 if bd=1, else vpc.
REQ-021 SHALL clear bits [1:0] of the EPC value when loading it on exception entry.
REQ-022 SHALL load IP[15:10] from hw_int on every clock edge, independent of any other event.
REQ-023 SHALL clear EXL on a clock edge with eret=1 and int_req=0.
REQ-024 SHALL ignore a mtc0 write on an edge where int_req=1, because exception entry wins.
REQ-025 SHALL let exception entry win when eret=1 and int_req=1 on the same edge.
REQ-026 SHALL apply a mtc0 write and an eret on the same edge together; if the write targets SR, EXL SHALL come from eret (0).
REQ-027 SHALL show written values on rdata and epc_out from the cycle after the write edge, with no same-cycle bypass.
REQ-028 SHALL drive epc_out from the EPC register only, with no bypass.

Reset
REQ-029 SHALL, on an edge with reset=1, set SR, Cause and EPC to 0; int_req SHALL then be 0 unless exc_code != 0.
REQ-030 SHALL give reset priority over int_req, eret and we, including reset asserted mid-handler.

Configuration
REQ-031 SHALL compile BadVAddr (reg 8) in when CP0_BADVADDR_EN is defined: add port badvaddr_in (input, 32), and load BadVAddr from it on exception entry when ExcCode is 4 or 5.
REQ-032 SHALL, with CP0_BADVADDR_EN defined, make BadVAddr read-only, with reset value 0.
REQ-033 SHALL, with CP0_BADVADDR_EN undefined, omit the badvaddr_in port and read reg 8 as 0.

Structure
REQ-034 SHALL take from shared package cp0_pkg the register numbers (8, 12, 13, 14, 15), the SR/Cause bit positions, the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), the PRId value and the handler address 0x0000_4180.
REQ-035 SHALL place the int_req and priority logic in one sub-module, cp0_int_arb; all register state SHALL stay in cp0_exc_unit.

Verification
REQ-036 SHALL test: mtc0 SR=0x0000_0401, then hw_int=6'b000001 -> int_req=1 in the same cycle; next cycle EXL=1, ExcCode=0 and IP=0x0400.
REQ-037 SHALL test: exc_code=12, vpc=0x0000_3010, bd=1 -> EPC=0x0000_300C, Cause=0x8000_0030 and SR.EXL=1.
REQ-038 SHALL test: with EXL=1, exc_code=10 -> int_req=0; then eret -> EXL=0, and int_req rises on the next cycle if exc_code is still 10.
REQ-039 SHALL test: mtc0 EPC=0x0000_3040 together with int_req=1 on the same edge -> EPC=vpc, and the write is dropped.
REQ-040 SHALL test: reset asserted while EXL=1 and hw_int active -> SR=Cause=EPC=0 next cycle, int_req=0, and reading reg 15 returns 0x0000_4CE0.
REQ-041 SHALL test with CP0_BADVADDR_EN defined: exc_code=4, badvaddr_in=0x0000_0003 -> reg 8 reads 0x0000_0003.
